// File: rtl/root_power_arbiter_if.sv
// Requester handshake and root-interconnect steering bundle for the root-power arbiter.
interface root_power_arbiter_if #(
    parameter int NN    = 4,
    parameter int NB    = 4,
    parameter int LEN_W = 8
);
    localparam int NN_W   = (NN > 1) ? $clog2(NN) : 1;
    localparam int BANK_W = (NB > 1) ? $clog2(NB) : 1;

    logic [NN-1:0]              req_valid;
    logic [NN-1:0][BANK_W-1:0]  req_bank;
    logic [NN-1:0][LEN_W-1:0]   req_len;
    logic [NN-1:0]              req_ready;
    logic [NN-1:0]              active;
    logic [NN-1:0]              done;
    logic [NB-1:0][NN_W-1:0]    ntt_intt_select;
    logic [NB-1:0]              bank_busy;
    logic [NN-1:0][BANK_W-1:0]  root_select;
    logic [NN-1:0]              root_select_valid;

    modport master (
        output req_valid, req_bank, req_len,
        input  req_ready, active, done, ntt_intt_select, bank_busy,
               root_select, root_select_valid
    );

    modport slave (
        input  req_valid, req_bank, req_len,
        output req_ready, active, done, ntt_intt_select, bank_busy,
               root_select, root_select_valid
    );
endinterface

// File: rtl/root_power_arbiter_chk.sv
// Ownership invariants of the root-power arbiter: each busy bank has exactly one
// active owner and no requester owns two banks at once.
module root_power_arbiter_chk #(
    parameter int NN   = 4,
    parameter int NB   = 4,
    parameter int NN_W = (NN > 1) ? $clog2(NN) : 1
) (
    input logic                      clk,
    input logic                      rst,
    input logic [NB-1:0]             bank_busy,
    input logic [NB-1:0][NN_W-1:0]   owner,
    input logic [NN-1:0]             active
);
    logic owner_ok_s;
    logic unique_ok_s;

    // Cross-check busy banks against the active vector
    always_comb begin
        owner_ok_s  = ($countones(active) == $countones(bank_busy));
        unique_ok_s = 1'b1;
        for (int b = 0; b < NB; b++) begin
            owner_ok_s = owner_ok_s && (!bank_busy[b] || active[owner[b]]);
            for (int c = b + 1; c < NB; c++) begin
                unique_ok_s = unique_ok_s &&
                              !(bank_busy[b] && bank_busy[c] && (owner[b] == owner[c]));
            end
        end
    end

    a_active_owner: assert property (@(posedge clk) disable iff (rst) owner_ok_s)
        else $error("root_power_arbiter: active vector disagrees with bank owners");

    a_single_bank: assert property (@(posedge clk) disable iff (rst) unique_ok_s)
        else $error("root_power_arbiter: requester owns two banks");
endmodule

// File: rtl/root_power_arbiter.sv
// Per-bank round-robin arbiter for the shared root-power RAM banks. Drives the address-path
// owner select and a return-path select delayed by the interconnect plus RAM read latency.
module root_power_arbiter #(
    parameter int NN      = 4,
    parameter int NB      = 4,
    parameter int LEN_W   = 8,
    parameter int RET_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    root_power_arbiter_if.slave  bus
);
    localparam int NN_W   = (NN > 1) ? $clog2(NN) : 1;
    localparam int BANK_W = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} bank_state_e;

    bank_state_e        state_r     [NB];
    bank_state_e        state_nxt_s [NB];
    logic [NN_W-1:0]    owner_r     [NB];
    logic [NN_W-1:0]    owner_nxt_s [NB];
    logic [LEN_W-1:0]   cnt_r       [NB];
    logic [LEN_W-1:0]   cnt_nxt_s   [NB];
    logic [NN_W-1:0]    ptr_r       [NB];
    logic [NN_W-1:0]    ptr_nxt_s   [NB];
    logic [NN-1:0]      elig_s      [NB];
    logic [NN_W-1:0]    win_s       [NB];
    logic [NB-1:0]      grant_s;
    logic [NN-1:0]      req_ready_s;
    logic [NN-1:0]      active_s;
    logic [NN-1:0]      done_s;
    logic [BANK_W-1:0]  act_bank_s  [NN];
    logic [RET_LAT-1:0] pipe_v_r    [NN];
    logic [BANK_W-1:0]  pipe_bank_r [NN][RET_LAT];

    function automatic int rr_idx(input logic [NN_W-1:0] ptr, input int k);
        return (int'(ptr) + k) % NN;
    endfunction

    // A zero length still moves one beat, so it loads the same count as a length of one
    function automatic logic [LEN_W-1:0] len_to_cnt(input logic [LEN_W-1:0] len);
        return (len == '0) ? '0 : len - LEN_W'(1'b1);
    endfunction

    // Per-requester view of the bank it owns and whether this is its final beat
    always_comb begin
        active_s = '0;
        done_s   = '0;
        for (int i = 0; i < NN; i++) begin
            act_bank_s[i] = '0;
            for (int b = 0; b < NB; b++) begin
                active_s[i]   = active_s[i] | ((state_r[b] == S_BUSY) && (owner_r[b] == NN_W'(i)));
                done_s[i]     = done_s[i] | ((state_r[b] == S_BUSY) && (owner_r[b] == NN_W'(i))
                                             && (cnt_r[b] == '0));
                act_bank_s[i] = ((state_r[b] == S_BUSY) && (owner_r[b] == NN_W'(i)))
                                ? BANK_W'(b) : act_bank_s[i];
            end
        end
    end

    // Bank FSM next state: a bank takes a new owner when idle or on its final beat
    always_comb begin
        req_ready_s = '0;
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < NN; i++) begin
                elig_s[b][i] = bus.req_valid[i] && (bus.req_bank[i] == BANK_W'(b))
                               && (int'(bus.req_bank[i]) < NB)
                               && !(active_s[i] && !done_s[i]);
            end
            // Scan downward so the eligible requester nearest the pointer is the last written
            win_s[b] = '0;
            for (int k = NN - 1; k >= 0; k--) begin
                win_s[b] = elig_s[b][rr_idx(ptr_r[b], k)] ? NN_W'(rr_idx(ptr_r[b], k)) : win_s[b];
            end
            grant_s[b]  = (|elig_s[b]) && ((state_r[b] == S_IDLE) || (cnt_r[b] == '0)) && !rst;
            req_ready_s = req_ready_s | (grant_s[b] ? (NN'(1'b1) << win_s[b]) : '0);

            case (state_r[b])
                S_IDLE:  state_nxt_s[b] = grant_s[b] ? S_BUSY : S_IDLE;
                S_BUSY:  state_nxt_s[b] = (grant_s[b] || (cnt_r[b] != '0)) ? S_BUSY : S_IDLE;
                default: state_nxt_s[b] = S_IDLE;
            endcase

            owner_nxt_s[b] = grant_s[b] ? win_s[b] : owner_r[b];
            ptr_nxt_s[b]   = grant_s[b] ? NN_W'((int'(win_s[b]) + 1) % NN) : ptr_r[b];
            cnt_nxt_s[b]   = grant_s[b] ? len_to_cnt(bus.req_len[win_s[b]])
                           : ((cnt_r[b] != '0) ? cnt_r[b] - LEN_W'(1'b1) : cnt_r[b]);
        end
    end

    // Bank FSM state, owner, beat counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                state_r[b] <= S_IDLE;
                owner_r[b] <= '0;
                cnt_r[b]   <= '0;
                ptr_r[b]   <= '0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                state_r[b] <= state_nxt_s[b];
                owner_r[b] <= owner_nxt_s[b];
                cnt_r[b]   <= cnt_nxt_s[b];
                ptr_r[b]   <= ptr_nxt_s[b];
            end
        end
    end

    // Return-path delay line; bank fields only advance with valid data so the tail holds
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NN; i++) begin
                pipe_v_r[i] <= '0;
                for (int k = 0; k < RET_LAT; k++) begin
                    pipe_bank_r[i][k] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < NN; i++) begin
                pipe_v_r[i][0] <= active_s[i];
                if (active_s[i]) begin
                    pipe_bank_r[i][0] <= act_bank_s[i];
                end
                for (int k = 1; k < RET_LAT; k++) begin
                    pipe_v_r[i][k] <= pipe_v_r[i][k-1];
                    if (pipe_v_r[i][k-1]) begin
                        pipe_bank_r[i][k] <= pipe_bank_r[i][k-1];
                    end
                end
            end
        end
    end

    // Interface outputs, decoded from registered state only (req_ready aside)
    always_comb begin
        bus.req_ready = req_ready_s;
        bus.active    = active_s;
        bus.done      = done_s;
        for (int b = 0; b < NB; b++) begin
            bus.ntt_intt_select[b] = owner_r[b];
            bus.bank_busy[b]       = (state_r[b] == S_BUSY);
        end
        for (int i = 0; i < NN; i++) begin
            bus.root_select[i]       = pipe_bank_r[i][RET_LAT-1];
            bus.root_select_valid[i] = pipe_v_r[i][RET_LAT-1];
        end
    end

    root_power_arbiter_chk #(.NN(NN), .NB(NB), .NN_W(NN_W)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .bank_busy (bus.bank_busy),
        .owner     (bus.ntt_intt_select),
        .active    (bus.active)
    );
endmodule

// File: tb/tb_root_power_arbiter.sv
// Directed self-checking bench for root_power_arbiter: inputs change 1 time unit after the
// rising edge and outputs are compared 2 units later.
module tb_root_power_arbiter;
    localparam int NN      = 4;
    localparam int NB      = 4;
    localparam int LEN_W   = 8;
    localparam int RET_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    root_power_arbiter_if #(.NN(NN), .NB(NB), .LEN_W(LEN_W)) bus ();

    root_power_arbiter #(.NN(NN), .NB(NB), .LEN_W(LEN_W), .RET_LAT(RET_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.req_valid = '0;
        bus.req_bank  = '0;
        bus.req_len   = '0;
    endtask

    task automatic set_req(input int i, input int bank, input int len);
        bus.req_valid[i] = 1'b1;
        bus.req_bank[i]  = 2'(bank);
        bus.req_len[i]   = 8'(len);
    endtask

    int t4_act [4] = '{3, 3, 1, 1};
    int t4_done[4] = '{0, 2, 0, 1};
    int t4_busy[4] = '{9, 9, 1, 1};
    int beats;
    int done_at;

    initial begin
        clear_req();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        #2;
        check("rst_active", 32'(bus.active), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_busy", 32'(bus.bank_busy), 32'h0);
        check("rst_nis", 32'(bus.ntt_intt_select), 32'h0);
        check("rst_rsv", 32'(bus.root_select_valid), 32'h0);
        check("rst_rsel", 32'(bus.root_select), 32'h0);
        step();

        // Single burst: req0 -> bank 2, len 3
        set_req(0, 2, 3);
        #2;
        check("t1_ready", 32'(bus.req_ready), 32'h1);
        step();
        clear_req();
        for (int c = 1; c <= 7; c++) begin
            #2;
            check("t1_active", 32'(bus.active), (c <= 3) ? 32'h1 : 32'h0);
            check("t1_done", 32'(bus.done), (c == 3) ? 32'h1 : 32'h0);
            check("t1_busy", 32'(bus.bank_busy), (c <= 3) ? 32'h4 : 32'h0);
            check("t1_rsv", 32'(bus.root_select_valid), (c >= 4 && c <= 6) ? 32'h1 : 32'h0);
            if (c >= 4) check("t1_rsel0", 32'(bus.root_select[0]), 32'h2);
            step();
        end

        // Contention on bank 0: req1 first, req3 on req1's final beat
        set_req(1, 0, 2);
        set_req(3, 0, 2);
        #2;
        check("t2_ready_c0", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid[1] = 1'b0;
        #2;
        check("t2_ready_c1", 32'(bus.req_ready), 32'h0);
        check("t2_active_c1", 32'(bus.active), 32'h2);
        step();
        #2;
        check("t2_active_c2", 32'(bus.active), 32'h2);
        check("t2_done_c2", 32'(bus.done), 32'h2);
        check("t2_ready_c2", 32'(bus.req_ready), 32'h8);
        step();
        clear_req();
        #2;
        check("t2_active_c3", 32'(bus.active), 32'h8);
        check("t2_nis0_c3", 32'(bus.ntt_intt_select[0]), 32'h3);
        step();
        #2;
        check("t2_active_c4", 32'(bus.active), 32'h8);
        check("t2_done_c4", 32'(bus.done), 32'h8);
        step();
        // Pointer wrapped to 0, so req0 beats req3
        set_req(0, 0, 1);
        set_req(3, 0, 1);
        #2;
        check("t2_ptr_wrap", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid[0] = 1'b0;
        #2;
        check("t2_ready_c6", 32'(bus.req_ready), 32'h8);
        check("t2_active_c6", 32'(bus.active), 32'h1);
        step();
        clear_req();
        repeat (4) step();

        // Round-robin: all requesters hammer bank 1 with len 1
        for (int i = 0; i < NN; i++) set_req(i, 1, 1);
        for (int c = 0; c < 8; c++) begin
            #2;
            check("t3_ready", 32'(bus.req_ready), 32'h1 << (c % 4));
            if (c > 0) begin
                check("t3_active", 32'(bus.active), 32'h1 << ((c - 1) % 4));
                check("t3_busy", 32'(bus.bank_busy), 32'h2);
            end
            step();
        end
        clear_req();
        repeat (4) step();

        // Parallel banks: req0 -> bank0 len 4, req1 -> bank3 len 2
        set_req(0, 0, 4);
        set_req(1, 3, 2);
        #2;
        check("t4_ready", 32'(bus.req_ready), 32'h3);
        step();
        clear_req();
        for (int c = 1; c <= 4; c++) begin
            #2;
            check("t4_active", 32'(bus.active), 32'(t4_act[c-1]));
            check("t4_done", 32'(bus.done), 32'(t4_done[c-1]));
            check("t4_busy", 32'(bus.bank_busy), 32'(t4_busy[c-1]));
            if (c == 1) check("t4_nis3", 32'(bus.ntt_intt_select[3]), 32'h1);
            if (c == 4) begin
                check("t4_rsv", 32'(bus.root_select_valid), 32'h3);
                check("t4_rsel1", 32'(bus.root_select[1]), 32'h3);
                check("t4_rsel0", 32'(bus.root_select[0]), 32'h0);
            end
            step();
        end
        repeat (4) step();

        // len 0 is a single beat
        set_req(2, 3, 0);
        #2;
        check("t5_ready", 32'(bus.req_ready), 32'h4);
        step();
        clear_req();
        #2;
        check("t5_active", 32'(bus.active), 32'h4);
        check("t5_done", 32'(bus.done), 32'h4);
        step();
        #2;
        check("t5_after", 32'(bus.active), 32'h0);
        step();
        repeat (4) step();

        // len 255: full-width count without wrap
        set_req(3, 2, 255);
        #2;
        check("t6_ready", 32'(bus.req_ready), 32'h8);
        step();
        clear_req();
        beats   = 0;
        done_at = 0;
        for (int c = 1; c <= 300; c++) begin
            #2;
            if (bus.active[3]) beats++;
            if (bus.done[3]) done_at = c;
            if (!bus.active[3]) break;
            step();
        end
        check("t6_beats", 32'(beats), 32'd255);
        check("t6_done_at", 32'(done_at), 32'd255);
        step();
        repeat (4) step();

        // Re-request held through the burst is only taken on the final beat
        set_req(2, 1, 2);
        #2;
        check("t7_ready_c0", 32'(bus.req_ready), 32'h4);
        step();
        #2;
        check("t7_ready_c1", 32'(bus.req_ready), 32'h0);
        check("t7_active_c1", 32'(bus.active), 32'h4);
        step();
        #2;
        check("t7_ready_c2", 32'(bus.req_ready), 32'h4);
        check("t7_done_c2", 32'(bus.done), 32'h4);
        step();
        clear_req();
        #2;
        check("t7_active_c3", 32'(bus.active), 32'h4);
        check("t7_done_c3", 32'(bus.done), 32'h0);
        step();
        #2;
        check("t7_done_c4", 32'(bus.done), 32'h4);
        step();
        repeat (4) step();

        // Reset at beat 2 of a len-5 burst
        set_req(0, 0, 5);
        #2;
        check("t8_ready", 32'(bus.req_ready), 32'h1);
        step();
        clear_req();
        #2;
        check("t8_active_c1", 32'(bus.active), 32'h1);
        step();
        #2;
        check("t8_active_c2", 32'(bus.active), 32'h1);
        rst = 1'b1;
        step();
        #2;
        rst = 1'b0;
        check("t8_active", 32'(bus.active), 32'h0);
        check("t8_done", 32'(bus.done), 32'h0);
        check("t8_busy", 32'(bus.bank_busy), 32'h0);
        check("t8_nis", 32'(bus.ntt_intt_select), 32'h0);
        check("t8_rsel", 32'(bus.root_select), 32'h0);
        check("t8_rsv_c3", 32'(bus.root_select_valid), 32'h0);
        for (int k = 0; k < RET_LAT; k++) begin
            step();
            #2;
            check("t8_rsv", 32'(bus.root_select_valid), 32'h0);
            check("t8_done_after", 32'(bus.done), 32'h0);
        end
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
